// File: rtl/cpu_stack.sv
// LIFO stack with a registered top-of-stack word and a (DEPTH-1)-entry backing array.
// Sticky overflow/underflow flags; flush discards contents without touching the flags.
module cpu_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             flush,
    input  logic             clr_err,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0] top_q, top_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty_q, full_q;

    logic [WIDTH-1:0] mem_q [DEPTH-1];
    logic             wr_en;
    logic [CW-1:0]    wr_idx, rd_idx;
    logic [WIDTH-1:0] rd_data;

    assign empty_q = (count_q == '0);
    assign full_q  = (count_q == CW'(DEPTH));

    // Slot count-1 receives the old top on push; slot count-2 becomes the new top on pop.
    assign wr_idx = count_q - CW'(1);
    assign rd_idx = count_q - CW'(2);

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            if (rd_idx == CW'(i)) rd_data = mem_q[i];
        end
    end

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q & ~clr_err;
        unf_d   = unf_q & ~clr_err;
        wr_en   = 1'b0;
        if (flush) begin
            top_d   = '0;
            count_d = '0;
        end else if (push && pop) begin
            top_d = din;
            if (empty_q) begin
                count_d = CW'(1);
                unf_d   = 1'b1;
            end
        end else if (push) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                wr_en   = !empty_q;
                top_d   = din;
                count_d = count_q + CW'(1);
            end
        end else if (pop) begin
            if (empty_q) begin
                unf_d = 1'b1;
            end else begin
                top_d   = (count_q == CW'(1)) ? '0 : rd_data;
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; stale words are unreachable because count gates every read.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            if (wr_en && wr_idx == CW'(i)) mem_q[i] <= top_q;
        end
    end

    assign top   = top_q;
    assign count = count_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_cpu_stack.sv
// Bench for cpu_stack: queue-based reference model for the 16x4 instance, directed
// constants for an 8x5 instance.
module tb_cpu_stack;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push, pop, flush, clr_err;
    logic [15:0] din;
    logic [15:0] top;
    logic [2:0]  count;
    logic        empty, full, ovf, unf;

    logic        push_b, pop_b;
    logic [7:0]  din_b;
    logic [7:0]  top_b;
    logic [2:0]  count_b;
    logic        empty_b, full_b, ovf_b, unf_b;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_q[$];
    logic        m_ovf, m_unf;

    always #5 clk = ~clk;

    cpu_stack #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din), .flush(flush),
        .clr_err(clr_err), .top(top), .count(count), .empty(empty), .full(full),
        .ovf(ovf), .unf(unf)
    );

    cpu_stack #(.WIDTH(8), .DEPTH(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .push(push_b), .pop(pop_b), .din(din_b), .flush(1'b0),
        .clr_err(1'b0), .top(top_b), .count(count_b), .empty(empty_b), .full(full_b),
        .ovf(ovf_b), .unf(unf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_apply(input logic p, input logic po, input logic f, input logic c,
                               input logic [15:0] d);
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (f) begin
            m_q.delete();
        end else if (p && po) begin
            if (m_q.size() == 0) begin
                m_q.push_back(d);
                m_unf = 1'b1;
            end else begin
                m_q[m_q.size() - 1] = d;
            end
        end else if (p) begin
            if (m_q.size() == D) m_ovf = 1'b1;
            else m_q.push_back(d);
        end else if (po) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else void'(m_q.pop_back());
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] mtop;
        mtop = (m_q.size() > 0) ? m_q[m_q.size() - 1] : 16'h0;
        check({tag, ".top"}, 32'(top), 32'(mtop));
        check({tag, ".count"}, 32'(count), 32'(m_q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(m_q.size() == D));
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, ".unf"}, 32'(unf), 32'(m_unf));
    endtask

    task automatic step(input string tag, input logic p, input logic po, input logic f,
                        input logic c, input logic [15:0] d);
        push = p; pop = po; flush = f; clr_err = c; din = d;
        @(posedge clk);
        #1;
        model_apply(p, po, f, c, d);
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    task automatic step_b(input string tag, input logic p, input logic po, input logic [7:0] d,
                          input logic [7:0] etop, input logic [2:0] ecnt, input logic eempty,
                          input logic efull);
        push_b = p; pop_b = po; din_b = d;
        @(posedge clk);
        #1;
        push_b = 1'b0; pop_b = 1'b0;
        check({tag, ".top"}, 32'(top_b), 32'(etop));
        check({tag, ".count"}, 32'(count_b), 32'(ecnt));
        check({tag, ".empty"}, 32'(empty_b), 32'(eempty));
        check({tag, ".full"}, 32'(full_b), 32'(efull));
    endtask

    initial begin
        rst_n = 1'b0;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; din = '0;
        push_b = 1'b0; pop_b = 1'b0; din_b = '0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill and drain
        step("fill1", 1, 0, 0, 0, 16'h1111);
        step("fill2", 1, 0, 0, 0, 16'h2222);
        step("fill3", 1, 0, 0, 0, 16'h3333);
        step("fill4", 1, 0, 0, 0, 16'h4444);
        step("ovf", 1, 0, 0, 0, 16'h5555);
        step("clr_ovf", 0, 0, 0, 1, 16'h0);
        step("repl_full", 1, 1, 0, 0, 16'h4444);
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 0, 0, 16'h0);

        // Underflow
        step("unf_pop", 0, 1, 0, 0, 16'h0);
        step("clr_unf", 0, 0, 0, 1, 16'h0);
        step("unf_pp", 1, 1, 0, 0, 16'hABCD);
        step("clr_set", 0, 1, 0, 1, 16'h0);
        step("unf_again", 0, 1, 0, 1, 16'h0);
        step("clr2", 0, 0, 0, 1, 16'h0);

        // Replace
        step("r_push1", 1, 0, 0, 0, 16'h1111);
        step("r_push2", 1, 0, 0, 0, 16'h2222);
        step("replace", 1, 1, 0, 0, 16'h7777);
        step("r_pop", 0, 1, 0, 0, 16'h0);
        step("r_pop2", 0, 1, 0, 0, 16'h0);

        // Flush with push
        step("f_push1", 1, 0, 0, 0, 16'h0101);
        step("f_push2", 1, 0, 0, 0, 16'h0202);
        step("f_push3", 1, 0, 0, 0, 16'h0303);
        step("flush", 1, 0, 1, 0, 16'h0404);
        step("f_pop", 0, 1, 0, 0, 16'h0);

        // Reset asserted mid-cycle
        step("rs_push1", 1, 0, 0, 0, 16'h0A0A);
        step("rs_push2", 1, 0, 0, 0, 16'h0B0B);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, 1, 0, 0, 16'h0);
        step("post_rst2", 1, 0, 0, 1, 16'h1234);

        // Random traffic, alternating push-heavy and pop-heavy phases
        for (int i = 0; i < 400; i++) begin
            logic p, po, f, c;
            int pp;
            pp = ((i / 40) % 2 == 0) ? 70 : 30;
            p  = ($urandom_range(0, 99) < pp);
            po = ($urandom_range(0, 99) < 100 - pp);
            f  = ($urandom_range(0, 31) == 0);
            c  = ($urandom_range(0, 7) == 0);
            step("rand", p, po, f, c, 16'($urandom));
        end

        // Non-power-of-two depth instance
        step("b_flush", 1, 0, 1, 0, 16'h0);
        step_b("b_fill1", 1, 0, 8'h11, 8'h11, 3'd1, 0, 0);
        step_b("b_fill2", 1, 0, 8'h22, 8'h22, 3'd2, 0, 0);
        step_b("b_fill3", 1, 0, 8'h33, 8'h33, 3'd3, 0, 0);
        step_b("b_fill4", 1, 0, 8'h44, 8'h44, 3'd4, 0, 0);
        step_b("b_fill5", 1, 0, 8'h55, 8'h55, 3'd5, 0, 1);
        check("b_ovf_clear", 32'(ovf_b), 32'd0);
        step_b("b_ovf", 1, 0, 8'h66, 8'h55, 3'd5, 0, 1);
        check("b_ovf_set", 32'(ovf_b), 32'd1);
        step_b("b_drain1", 0, 1, 8'h0, 8'h44, 3'd4, 0, 0);
        step_b("b_drain2", 0, 1, 8'h0, 8'h33, 3'd3, 0, 0);
        step_b("b_drain3", 0, 1, 8'h0, 8'h22, 3'd2, 0, 0);
        step_b("b_drain4", 0, 1, 8'h0, 8'h11, 3'd1, 0, 0);
        step_b("b_drain5", 0, 1, 8'h0, 8'h00, 3'd0, 1, 0);
        check("b_unf_clear", 32'(unf_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
